// File: rtl/tdm_arb_pkg.sv
// Shared types and defaults for the TDM slot arbiter.
// Pure declarations, no logic; no flow control of its own.
package tdm_arb_pkg;

    localparam int NUM_SLOTS_DEF = 3;
    localparam int SLOT_W_DEF    = 2;
    localparam int DATA_W_DEF    = 8;
    localparam int MISS_W_DEF    = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // A slot number is usable only when it names an existing requester.
    function automatic logic slot_legal(input logic [31:0] slot, input logic [31:0] num_slots);
        return slot < num_slots;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: +1 per cycle with inc high, sticks at all-ones.
// Latency: count updates on the edge after inc; no backpressure (always accepts inc).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_slot_arbiter.sv
// TDM arbiter: grants the output register to the owner of the current slot.
// Latency: eligible slot at edge N -> out_valid and gnt pulse after edge N.
// Backpressure: output held while !out_ready; eligible slots lost are counted.
// Embedded assertions/cover enabled by defining TDM_ARB_FORMAL_CHECKS_EN.
module tdm_slot_arbiter
    import tdm_arb_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int SLOT_W    = SLOT_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MISS_W    = MISS_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        slot_valid,
    input  logic [SLOT_W-1:0]           slot,
    input  logic [NUM_SLOTS-1:0]        req,
    input  logic [NUM_SLOTS*DATA_W-1:0] data,
    output logic [NUM_SLOTS-1:0]        gnt,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [SLOT_W-1:0]           out_slot,
    output logic [MISS_W-1:0]           miss_cnt,
    output logic                        err_slot
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   legal;
    logic                   eligible;
    logic                   free;
    logic                   capture;
    logic                   miss_inc;
    logic [NUM_SLOTS-1:0]   sel_onehot;
    logic [DATA_W-1:0]      sel_data;

    // Decode the slot once: onehot owner and that owner's payload.
    always_comb begin
        sel_onehot = '0;
        sel_data   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot == SLOT_W'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_data      = data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign legal     = slot_legal(32'(slot), 32'(NUM_SLOTS));
    assign eligible  = slot_valid && legal && (|(sel_onehot & req));
    assign out_valid = (state == HOLD);
    assign free      = !out_valid || out_ready;
    assign capture   = eligible && free;
    assign miss_inc  = eligible && !free;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // A completing transfer either refills back-to-back or empties.
                if (out_ready) begin
                    state_nxt = capture ? HOLD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            out_data <= '0;
            out_slot <= '0;
            err_slot <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= capture ? sel_onehot : '0;
            if (capture) begin
                out_data <= sel_data;
                out_slot <= slot;
            end
            if (slot_valid && !legal) begin
                err_slot <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (MISS_W)
    ) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (miss_inc),
        .count (miss_cnt)
    );

`ifdef TDM_ARB_FORMAL_CHECKS_EN
    logic chk_armed = 1'b0;

    always_ff @(posedge clk) begin
        chk_armed <= 1'b1;
    end

    a_gnt_onehot0: assert property (@(posedge clk)
        chk_armed && !reset |-> $onehot0(gnt));

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_gnt_src
        a_gnt_src: assert property (@(posedge clk)
            chk_armed && !reset && gnt[gi] |->
                $past(req[gi]) && ($past(slot) == SLOT_W'(gi)));
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        chk_armed && out_valid && !out_ready |=>
            out_valid && $stable(out_data) && $stable(out_slot));

    a_miss_mono: assert property (@(posedge clk)
        chk_armed && !reset && !$past(reset) |-> miss_cnt >= $past(miss_cnt));

    a_err_sticky: assert property (@(posedge clk)
        chk_armed && !reset && !$past(reset) && $past(err_slot) |-> err_slot);

    c_b2b_all: cover property (@(posedge clk)
        chk_armed && !reset && gnt == NUM_SLOTS'(1)
        ##1 gnt == NUM_SLOTS'(2) ##1 gnt == NUM_SLOTS'(4));
`else
    // Checks compiled out; datapath and ports are unchanged.
`endif

endmodule

// File: tb/tb_tdm_slot_arbiter.sv
// Randomized and directed stimulus against a transaction-level model of the arbiter.
module tb_tdm_slot_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        slot_valid;
    logic [1:0]  slot;
    logic [2:0]  req;
    logic [23:0] data;
    logic        out_ready;

    logic [2:0]  gnt,  gnt_b;
    logic        out_valid, out_valid_b;
    logic [7:0]  out_data, out_data_b;
    logic [1:0]  out_slot, out_slot_b;
    logic [7:0]  miss_cnt;
    logic [1:0]  miss_cnt_b;
    logic        err_slot, err_slot_b;

    int checks   = 0;
    int failures = 0;

    // Model state: what the output register holds, grants, lost slots, error flag.
    bit         m_valid;
    logic [7:0] m_data;
    logic [1:0] m_slot;
    logic [2:0] m_gnt;
    int         m_miss;
    bit         m_err;

    tdm_slot_arbiter u_dut (
        .clk(clk), .reset(reset), .slot_valid(slot_valid), .slot(slot), .req(req),
        .data(data), .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_slot(out_slot), .miss_cnt(miss_cnt), .err_slot(err_slot)
    );

    tdm_slot_arbiter #(.MISS_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .slot_valid(slot_valid), .slot(slot), .req(req),
        .data(data), .gnt(gnt_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_slot(out_slot_b), .miss_cnt(miss_cnt_b), .err_slot(err_slot_b)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: advance the model from the current inputs, then compare all outputs.
    task automatic tick();
        int  s;
        bit  elig, cap;
        s    = int'(slot);
        elig = slot_valid && (s < 3) && req[s];
        cap  = elig && (!m_valid || out_ready);
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 0; m_data = 0; m_slot = 0; m_gnt = 0; m_miss = 0; m_err = 0;
        end else begin
            if (elig && m_valid && !out_ready) m_miss++;
            if (slot_valid && s >= 3) m_err = 1;
            m_gnt = cap ? (3'b001 << s) : 3'b000;
            if (cap) begin
                m_valid = 1;
                m_data  = data[s*8 +: 8];
                m_slot  = slot;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_slot",  32'(out_slot),  32'(m_slot));
        chk("gnt",       32'(gnt),       32'(m_gnt));
        chk("miss_cnt",  32'(miss_cnt),  32'(sat(m_miss, 255)));
        chk("miss_sat",  32'(miss_cnt_b), 32'(sat(m_miss, 3)));
        chk("err_slot",  32'(err_slot),  32'(m_err));
        chk("gnt_b",     32'(gnt_b),     32'(m_gnt));
    endtask

    task automatic next_slot();
        slot = (slot >= 2'd2) ? 2'd0 : slot + 2'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        slot  = 2'd0;
    endtask

    initial begin
        logic [7:0] exp_b2b [3];
        exp_b2b[0] = 8'h11; exp_b2b[1] = 8'h22; exp_b2b[2] = 8'h33;

        reset = 1'b1; slot_valid = 1'b0; slot = 2'd0; req = 3'b000;
        data = 24'h0; out_ready = 1'b0;
        m_valid = 0; m_data = 0; m_slot = 0; m_gnt = 0; m_miss = 0; m_err = 0;
        tick();
        do_reset();

        // Back-to-back transfers across all three slots.
        slot_valid = 1'b1; req = 3'b111; out_ready = 1'b1; data = 24'h332211;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_data", 32'(out_data), 32'(exp_b2b[i]));
            chk("b2b_gnt",  32'(gnt), 32'(3'b001 << i));
            next_slot();
        end
        req = 3'b000;
        tick(); next_slot();
        chk("b2b_miss", 32'(miss_cnt), 32'd0);

        // Slot-1 requester under backpressure for three slot-1 visits.
        do_reset();
        req = 3'b010; out_ready = 1'b0; data = 24'hC3B2A1;
        repeat (9) begin tick(); next_slot(); end
        chk("bp_miss",  32'(miss_cnt), 32'd2);
        chk("bp_slot",  32'(out_slot), 32'd1);
        chk("bp_data",  32'(out_data), 32'hB2);
        req = 3'b000; out_ready = 1'b1;
        tick(); next_slot();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // Illegal slot value.
        do_reset();
        req = 3'b111; slot = 2'd3;
        tick();
        chk("ill_gnt", 32'(gnt), 32'd0);
        chk("ill_err", 32'(err_slot), 32'd1);
        req = 3'b000; slot = 2'd0;
        repeat (3) begin tick(); next_slot(); end
        chk("ill_sticky", 32'(err_slot), 32'd1);

        // Slot input not yet valid.
        do_reset();
        slot_valid = 1'b0; req = 3'b111;
        repeat (5) begin tick(); next_slot(); end
        chk("nv_valid", 32'(out_valid), 32'd0);
        chk("nv_err",   32'(err_slot), 32'd0);

        // Reset while a transfer is stalled; requester re-granted afterwards.
        do_reset();
        slot_valid = 1'b1; req = 3'b001; out_ready = 1'b0; data = 24'h0000AA;
        tick(); next_slot();
        tick(); next_slot();
        reset = 1'b1;
        tick();
        reset = 1'b0; slot = 2'd0; out_ready = 1'b1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_miss",  32'(miss_cnt), 32'd0);
        tick(); next_slot();
        chk("rst_regnt", 32'(gnt), 32'd1);

        // Saturation of the narrow counter.
        do_reset();
        req = 3'b111; out_ready = 1'b0;
        repeat (8) begin tick(); next_slot(); end
        chk("sat_narrow", 32'(miss_cnt_b), 32'd3);
        chk("sat_wide",   32'(miss_cnt),   32'd7);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req        = 3'($urandom);
            data       = 24'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            slot_valid = ($urandom_range(0, 7) != 0);
            reset      = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) slot = 2'd3;
            tick();
            if (reset) slot = 2'd0;
            else next_slot();
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
